// File: rtl/quic_ctrl_pkg.sv
// Shared definitions for the quic_dec frame controller: state encoding,
// decoder word width and default timing constants.
package quic_ctrl_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned DEF_GAP_CYCLES = 10;
   localparam int unsigned DEF_TIMEOUT    = 1024;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

endpackage

// File: rtl/quic_frame_ctrl_if.sv
// Bundle of descriptor, memory and decoder signals around quic_frame_ctrl.
// master = controller side, slave = system/decoder side.
interface quic_frame_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 32
);
   logic              start_valid;
   logic              start_ready;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  start_len;
   logic              frame_abort;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;
   logic [31:0]       bitstream_input;
   logic              we;
   logic              next;
   logic              last_word;
   logic              decode_end;
   logic              frame_done;
   logic              frame_err;

   modport master (
      input  start_valid, start_addr, start_len, frame_abort, mem_rdata, next, decode_end,
      output start_ready, mem_rd, mem_addr, bitstream_input, we, last_word, frame_done, frame_err
   );

   modport slave (
      output start_valid, start_addr, start_len, frame_abort, mem_rdata, next, decode_end,
      input  start_ready, mem_rd, mem_addr, bitstream_input, we, last_word, frame_done, frame_err
   );
endinterface

// File: rtl/quic_word_fifo.sv
// Synchronous prefetch FIFO (power-of-2 depth) with push, pop and a flush
// that takes priority over both.
module quic_word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;

   // NOTE: non-blocking (<=) in every clocked block so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; count_q/pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/quic_frame_ctrl.sv
// Frame sequencer feeding quic_dec from word memory through a prefetch FIFO.
// Optional watchdog enabled by defining QUIC_FRAME_TIMEOUT_EN.
module quic_frame_ctrl
   import quic_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LEN_W      = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input logic                clk,
   input logic                reset_n,
   quic_frame_ctrl_if.master  bus
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [LEN_W-1:0]  delivered_q, delivered_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              rd_pend_q, rd_pend_d;
   logic              de_seen_q, de_seen_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              mem_rd_c, we_c, last_c, abort_c, timeout_hit;
   logic              fifo_push, fifo_pop, fifo_flush, fifo_empty;
   logic [WORD_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;

   // Read data returns one cycle after the strobe; drop it unless still streaming.
   assign fifo_push = rd_pend_q && (state_q == ST_STREAM);
   assign abort_c   = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) &&
                      (bus.frame_abort || timeout_hit);

   quic_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (fifo_push),
      .wdata_i (bus.mem_rdata),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      issued_d    = issued_q;
      delivered_d = delivered_q;
      gap_d       = gap_q;
      de_seen_d   = de_seen_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      mem_rd_c    = 1'b0;
      we_c        = 1'b0;
      last_c      = 1'b0;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_valid) begin
               if (bus.start_len != '0) begin
                  base_d      = bus.start_addr;
                  len_d       = bus.start_len;
                  issued_d    = '0;
                  delivered_d = '0;
                  de_seen_d   = 1'b0;
                  state_d     = ST_STREAM;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            we_c   = !fifo_empty;
            last_c = we_c && (delivered_q == len_q - LEN_W'(1));
            if (abort_c) begin
               fifo_flush = 1'b1;
               done_d     = 1'b1;
               err_d      = 1'b1;
               gap_d      = '0;
               state_d    = ST_GAP;
            end else begin
               // Credit check counts the read in flight so the FIFO can never overflow.
               if ((issued_q < len_q) &&
                   ((int'(fifo_count) + int'(rd_pend_q)) < int'(FIFO_DEPTH))) begin
                  mem_rd_c = 1'b1;
                  issued_d = issued_q + LEN_W'(1);
               end
               if (bus.decode_end) de_seen_d = 1'b1;
               if (we_c && bus.next) begin
                  fifo_pop    = 1'b1;
                  delivered_d = delivered_q + LEN_W'(1);
                  if (last_c) begin
                     fifo_flush = 1'b1;
                     state_d    = ST_DRAIN;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (abort_c) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = ST_GAP;
            end else if (bus.decode_end || de_seen_q) begin
               done_d  = 1'b1;
               gap_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            else                                 gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_pend_d = mem_rd_c;

`ifdef QUIC_FRAME_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   always_comb begin
      wd_d = '0;
      if ((state_d == state_q) &&
          ((state_q == ST_DRAIN) || ((state_q == ST_STREAM) && !fifo_pop)))
         wd_d = wd_q + WD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) wd_q <= '0;
      else          wd_q <= wd_d;
   end

   assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         gap_q       <= '0;
         rd_pend_q   <= 1'b0;
         de_seen_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         gap_q       <= gap_d;
         rd_pend_q   <= rd_pend_d;
         de_seen_q   <= de_seen_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.start_ready     = (state_q == ST_IDLE);
   assign bus.mem_rd          = mem_rd_c;
   assign bus.mem_addr        = base_q + ADDR_W'(issued_q);
   assign bus.bitstream_input = fifo_rdata;
   assign bus.we              = we_c;
   assign bus.last_word       = last_c;
   assign bus.frame_done      = done_q;
   assign bus.frame_err       = err_q;
endmodule

// File: tb/tb_quic_frame_ctrl.sv
// Directed bench for quic_frame_ctrl; the timeout scenario runs only when
// QUIC_FRAME_TIMEOUT_EN is defined (DUT built with TIMEOUT=16).
module tb_quic_frame_ctrl;
   logic clk;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   quic_frame_ctrl_if #(.ADDR_W(32), .LEN_W(32)) bus ();

   quic_frame_ctrl #(
      .ADDR_W(32), .LEN_W(32), .FIFO_DEPTH(4), .GAP_CYCLES(10), .TIMEOUT(16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'hA000_0000 + addr;
   endfunction

   // Word memory: data valid exactly one cycle after the read strobe.
   always @(posedge clk) begin
      bus.mem_rdata <= bus.mem_rd ? mem_word(bus.mem_addr) : 32'hDEAD_BEEF;
   end

   task automatic wait_idle(input string tag);
      int guard = 0;
      while (bus.start_ready !== 1'b1 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      tests_run++;
      if (bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_idle_timeout: start_ready=%b required 1", tag, bus.start_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.start_ready, bus.mem_rd, bus.we, bus.last_word, bus.frame_done, bus.frame_err}
          !== 6'b100000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b required 100000",
                  {bus.start_ready, bus.mem_rd, bus.we, bus.last_word, bus.frame_done, bus.frame_err});
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n_rd  = 0;
      int n_pop = 0;
      tests_run++;
      if (bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_ready: got %b required 1", bus.start_ready);
      end
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h100;
      bus.start_len   = 32'd3;
      bus.next        = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k == 1) bus.start_valid = 1'b0;
         if (bus.mem_rd) begin
            tests_run++;
            if (bus.mem_addr !== 32'h100 + n_rd) begin
               tests_failed++;
               $display("FAIL basic_addr: got %h required %h", bus.mem_addr, 32'h100 + n_rd);
            end
            n_rd++;
         end
         if (k == 2 || k == 3) begin
            tests_run++;
            if (bus.we !== (k == 3)) begin
               tests_failed++;
               $display("FAIL basic_first_we k=%0d: got %b required %b", k, bus.we, (k == 3));
            end
         end
         if (bus.we) begin
            tests_run++;
            if (bus.bitstream_input !== mem_word(32'h100 + n_pop) ||
                bus.last_word !== (n_pop == 2)) begin
               tests_failed++;
               $display("FAIL basic_word%0d: got %h/last=%b required %h/last=%b", n_pop,
                        bus.bitstream_input, bus.last_word, mem_word(32'h100 + n_pop), (n_pop == 2));
            end
            n_pop++;
         end
         if (k == 6 || k == 10 || k == 11 || k == 12) begin
            tests_run++;
            if ({bus.we, bus.frame_done, bus.frame_err} !== {1'b0, (k == 11), 1'b0}) begin
               tests_failed++;
               $display("FAIL basic_done k=%0d: we/done/err got %b required %b", k,
                        {bus.we, bus.frame_done, bus.frame_err}, {1'b0, (k == 11), 1'b0});
            end
         end
         if (k == 20 || k == 21) begin
            tests_run++;
            if (bus.start_ready !== (k == 21)) begin
               tests_failed++;
               $display("FAIL basic_gap k=%0d: start_ready got %b required %b", k,
                        bus.start_ready, (k == 21));
            end
         end
         if (k == 10) bus.decode_end = 1'b1;
         if (k == 11) bus.decode_end = 1'b0;
      end
      tests_run++;
      if (n_rd != 3 || n_pop != 3) begin
         tests_failed++;
         $display("FAIL basic_counts: reads=%0d pops=%0d required 3/3", n_rd, n_pop);
      end
   endtask

   task automatic test_backpressure();
      int n_rd  = 0;
      int n_pop = 0;
      int guard = 0;
      bus.next        = 1'b0;
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h200;
      bus.start_len   = 32'd8;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.start_valid = 1'b0;
         if (bus.mem_rd) begin
            tests_run++;
            if (bus.mem_addr !== 32'h200 + n_rd) begin
               tests_failed++;
               $display("FAIL bp_addr: got %h required %h", bus.mem_addr, 32'h200 + n_rd);
            end
            n_rd++;
         end
      end
      tests_run++;
      if (n_rd != 4) begin
         tests_failed++;
         $display("FAIL bp_reads_stalled: got %0d reads required 4", n_rd);
      end
      bus.next = 1'b1;
      while (n_pop < 8 && guard < 40) begin
         if (bus.we) begin
            tests_run++;
            if (bus.bitstream_input !== mem_word(32'h200 + n_pop) ||
                bus.last_word !== (n_pop == 7)) begin
               tests_failed++;
               $display("FAIL bp_word%0d: got %h/last=%b required %h/last=%b", n_pop,
                        bus.bitstream_input, bus.last_word, mem_word(32'h200 + n_pop), (n_pop == 7));
            end
            n_pop++;
            if (n_pop == 8) break;
         end
         @(negedge clk);
         guard++;
         if (bus.mem_rd) begin
            tests_run++;
            if (bus.mem_addr !== 32'h200 + n_rd) begin
               tests_failed++;
               $display("FAIL bp_addr: got %h required %h", bus.mem_addr, 32'h200 + n_rd);
            end
            n_rd++;
         end
      end
      tests_run++;
      if (n_pop != 8 || n_rd != 8) begin
         tests_failed++;
         $display("FAIL bp_counts: pops=%0d reads=%0d required 8/8", n_pop, n_rd);
      end
      @(negedge clk);
      tests_run++;
      if (bus.we !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drain_we: got %b required 0", bus.we);
      end
      bus.decode_end = 1'b1;
      @(negedge clk);
      bus.decode_end = 1'b0;
      tests_run++;
      if ({bus.frame_done, bus.frame_err} !== 2'b10) begin
         tests_failed++;
         $display("FAIL bp_done: done/err got %b required 10", {bus.frame_done, bus.frame_err});
      end
      wait_idle("bp");
   endtask

   task automatic test_abort();
      int n_pop = 0;
      bus.next        = 1'b1;
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h300;
      bus.start_len   = 32'd8;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.start_valid = 1'b0;
         if (bus.we) n_pop++;
      end
      @(negedge clk);
      tests_run++;
      if (n_pop != 2 || bus.we !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_setup: pops=%0d we=%b required 2/1", n_pop, bus.we);
      end
      bus.next        = 1'b0;
      bus.frame_abort = 1'b1;
      @(negedge clk);
      bus.frame_abort = 1'b0;
      tests_run++;
      if ({bus.frame_done, bus.frame_err, bus.we, bus.mem_rd, bus.start_ready} !== 5'b11000) begin
         tests_failed++;
         $display("FAIL abort_pulse: done/err/we/rd/ready got %b required 11000",
                  {bus.frame_done, bus.frame_err, bus.we, bus.mem_rd, bus.start_ready});
      end
      @(negedge clk);
      tests_run++;
      if ({bus.frame_done, bus.frame_err, bus.we} !== 3'b000) begin
         tests_failed++;
         $display("FAIL abort_after: done/err/we got %b required 000",
                  {bus.frame_done, bus.frame_err, bus.we});
      end
      wait_idle("abort");
   endtask

   task automatic test_zero_len();
      int n_rd = 0;
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h400;
      bus.start_len   = 32'd0;
      @(negedge clk);
      bus.start_valid = 1'b0;
      tests_run++;
      if ({bus.frame_done, bus.frame_err, bus.start_ready, bus.mem_rd} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL zero_len_done: done/err/ready/rd got %b required 1010",
                  {bus.frame_done, bus.frame_err, bus.start_ready, bus.mem_rd});
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.mem_rd) n_rd++;
      end
      tests_run++;
      if (n_rd != 0 || bus.frame_done !== 1'b0 || bus.start_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL zero_len_after: reads=%0d done=%b ready=%b required 0/0/1",
                  n_rd, bus.frame_done, bus.start_ready);
      end
   endtask

   task automatic test_reset_mid();
      int n_pop = 0;
      bus.next        = 1'b0;
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h500;
      bus.start_len   = 32'd6;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.start_valid = 1'b0;
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tests_run++;
      if ({bus.start_ready, bus.mem_rd, bus.we, bus.last_word, bus.frame_done, bus.frame_err}
          !== 6'b100000) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: got %b required 100000",
                  {bus.start_ready, bus.mem_rd, bus.we, bus.last_word, bus.frame_done, bus.frame_err});
      end
      // Fresh frame; decode_end arrives early, during STREAM.
      bus.next        = 1'b1;
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h600;
      bus.start_len   = 32'd2;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         bus.start_valid = 1'b0;
         bus.decode_end  = (k == 1);
         if (bus.we) begin
            tests_run++;
            if (bus.bitstream_input !== mem_word(32'h600 + n_pop) ||
                bus.last_word !== (n_pop == 1)) begin
               tests_failed++;
               $display("FAIL reset_mid_word%0d: got %h/last=%b required %h/last=%b", n_pop,
                        bus.bitstream_input, bus.last_word, mem_word(32'h600 + n_pop), (n_pop == 1));
            end
            n_pop++;
         end
         if (k == 5 || k == 6) begin
            tests_run++;
            if (bus.frame_done !== (k == 6)) begin
               tests_failed++;
               $display("FAIL early_end_done k=%0d: got %b required %b", k, bus.frame_done, (k == 6));
            end
         end
      end
      tests_run++;
      if (n_pop != 2) begin
         tests_failed++;
         $display("FAIL reset_mid_pops: got %0d required 2", n_pop);
      end
      wait_idle("reset_mid");
   endtask

`ifdef QUIC_FRAME_TIMEOUT_EN
   task automatic test_timeout();
      bus.next        = 1'b1;
      bus.start_valid = 1'b1;
      bus.start_addr  = 32'h700;
      bus.start_len   = 32'd1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.start_valid = 1'b0;
         if (k == 19 || k == 20) begin
            tests_run++;
            if ({bus.frame_done, bus.frame_err} !== {(k == 20), (k == 20)}) begin
               tests_failed++;
               $display("FAIL timeout_k%0d: done/err got %b required %b", k,
                        {bus.frame_done, bus.frame_err}, {(k == 20), (k == 20)});
            end
         end
      end
      wait_idle("timeout");
   endtask
`endif

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      reset_n         = 1'b0;
      bus.start_valid = 1'b0;
      bus.start_addr  = '0;
      bus.start_len   = '0;
      bus.frame_abort = 1'b0;
      bus.next        = 1'b0;
      bus.decode_end  = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_abort();
      test_zero_len();
      test_reset_mid();
`ifdef QUIC_FRAME_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
